// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-to-controller hazard interface: decode/redirect inputs and pipeline control outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DEPTH      = 3
);
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  logic                  d_valid;
  logic [REG_ADDR_W-1:0] d_rs1;
  logic [REG_ADDR_W-1:0] d_rs2;
  logic                  d_use_rs1;
  logic                  d_use_rs2;
  logic [REG_ADDR_W-1:0] d_rd;
  logic                  d_wr_en;
  logic                  d_is_load;
  logic                  d_halt;
  logic                  redirect;

  logic                  fetch_en;
  logic                  stall_fd;
  logic                  flush_fd;
  logic                  bubble_de;
  logic [SEL_W-1:0]      fwd_rs1_sel;
  logic [SEL_W-1:0]      fwd_rs2_sel;
  logic                  ohalt;

  // Decode/EX side: presents the instruction, consumes the control decisions.
  modport master (
    output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_wr_en, d_is_load, d_halt, redirect,
    input  fetch_en, stall_fd, flush_fd, bubble_de, fwd_rs1_sel, fwd_rs2_sel, ohalt
  );

  // Hazard controller side.
  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_wr_en, d_is_load, d_halt, redirect,
    output fetch_en, stall_fd, flush_fd, bubble_de, fwd_rs1_sel, fwd_rs2_sel, ohalt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the in-order pipelined core.
// Tracks writer info for DEPTH stages after decode, drives forwarding selects,
// load-use stall/bubble, redirect flush and a halt-drain FSM.
// Optional feature: define PERF_CNT_EN to add stall_cnt/flush_cnt cycle counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic                  is_load;
    logic                  halt;
    logic [REG_ADDR_W-1:0] rd;
  } shadow_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e           state_q, state_d;
  shadow_t          shadow_q [1:DEPTH];
  shadow_t          shadow_d [1:DEPTH];

  logic [SEL_W-1:0] rs1_hit_c, rs2_hit_c;
  logic             rs1_load_c, rs2_load_c;
  logic             rs1_lu_c, rs2_lu_c, load_use_c;
  logic             acc_c;
  logic             fetch_c, stall_c, flush_c, bubble_c, ohalt_c;
  logic [SEL_W-1:0] sel1_c, sel2_c;

  // Youngest matching writer per operand; scanning old to young lets the youngest overwrite.
  always_comb begin
    rs1_hit_c  = '0;
    rs2_hit_c  = '0;
    rs1_load_c = 1'b0;
    rs2_load_c = 1'b0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (shadow_q[k].valid && shadow_q[k].wr_en &&
          (shadow_q[k].rd == bus.d_rs1) && (bus.d_rs1 != '0)) begin
        rs1_hit_c  = SEL_W'(k);
        rs1_load_c = shadow_q[k].is_load && (k < int'(LOAD_STAGE));
      end
      if (shadow_q[k].valid && shadow_q[k].wr_en &&
          (shadow_q[k].rd == bus.d_rs2) && (bus.d_rs2 != '0)) begin
        rs2_hit_c  = SEL_W'(k);
        rs2_load_c = shadow_q[k].is_load && (k < int'(LOAD_STAGE));
      end
    end
  end

  // Load data not yet available for a used operand of a valid decode instruction.
  always_comb begin
    rs1_lu_c   = bus.d_valid && bus.d_use_rs1 && rs1_load_c;
    rs2_lu_c   = bus.d_valid && bus.d_use_rs2 && rs2_load_c;
    load_use_c = rs1_lu_c || rs2_lu_c;
  end

  // FSM next state and pipeline control outputs.
  always_comb begin
    state_d  = state_q;
    acc_c    = 1'b0;
    fetch_c  = 1'b0;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    ohalt_c  = 1'b0;
    sel1_c   = '0;
    sel2_c   = '0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (load_use_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
        sel1_c  = rs1_lu_c ? '0 : rs1_hit_c;
        sel2_c  = rs2_lu_c ? '0 : rs2_hit_c;
        acc_c   = bus.d_valid && !stall_c && !bus.redirect;
        fetch_c = !(acc_c && bus.d_halt);
        if (acc_c && bus.d_halt) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Redirects are ignored while draining; only in-flight work matters.
        stall_c  = load_use_c;
        bubble_c = load_use_c;
        sel1_c   = rs1_lu_c ? '0 : rs1_hit_c;
        sel2_c   = rs2_lu_c ? '0 : rs2_hit_c;
        if (shadow_q[DEPTH].valid && shadow_q[DEPTH].halt) begin
          ohalt_c = 1'b1;
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        ohalt_c = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Shadow shift: accepted decode enters stage 1, everything else moves down one stage.
  always_comb begin
    shadow_d[1] = '0;
    if (acc_c) begin
      shadow_d[1].valid   = 1'b1;
      shadow_d[1].wr_en   = bus.d_wr_en;
      shadow_d[1].is_load = bus.d_is_load;
      shadow_d[1].halt    = bus.d_halt;
      shadow_d[1].rd      = bus.d_rd;
    end
    for (int k = 2; k <= int'(DEPTH); k++) begin
      shadow_d[k] = shadow_q[k-1];
    end
  end

  // State and shadow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      for (int k = 1; k <= int'(DEPTH); k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef PERF_CNT_EN
  // Stall and redirect-flush cycle counters, wrapping, frozen once halted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state_q != ST_HALTED) begin
      if (stall_c) stall_cnt <= stall_cnt + 32'd1;
      if (flush_c) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

  assign bus.fetch_en    = fetch_c;
  assign bus.stall_fd    = stall_c;
  assign bus.flush_fd    = flush_c;
  assign bus.bubble_de   = bubble_c;
  assign bus.fwd_rs1_sel = sel1_c;
  assign bus.fwd_rs2_sel = sel2_c;
  assign bus.ohalt       = ohalt_c;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver applies one decode vector
// per cycle and queues its expected controls; a monitor checks them mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .DEPTH(3)) bus ();

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5),
    .DEPTH     (3),
    .LOAD_STAGE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    string       nm;
    logic        fe;
    logic        st;
    logic        fl;
    logic        bu;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        oh;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_scnt    = '0;
  logic [31:0] exp_fcnt    = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle: reset level, decode fields, redirect, then the expected controls.
  task automatic cyc(input string nm, input logic r,
                     input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic wr, input logic ld, input logic hlt,
                     input logic rdr,
                     input logic fe, input logic st, input logic fl, input logic bu,
                     input logic [1:0] s1, input logic [1:0] s2, input logic oh);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.d_valid   = v;
    bus.d_rs1     = rs1;
    bus.d_use_rs1 = u1;
    bus.d_rs2     = rs2;
    bus.d_use_rs2 = u2;
    bus.d_rd      = rd;
    bus.d_wr_en   = wr;
    bus.d_is_load = ld;
    bus.d_halt    = hlt;
    bus.redirect  = rdr;
    if (!r) begin
      exp_scnt = '0;
      exp_fcnt = '0;
    end
    e.nm = nm; e.fe = fe; e.st = st; e.fl = fl; e.bu = bu;
    e.s1 = s1; e.s2 = s2; e.oh = oh; e.scnt = exp_scnt; e.fcnt = exp_fcnt;
    sb_q.push_back(e);
    if (r) begin
      exp_scnt = exp_scnt + 32'(st);
      exp_fcnt = exp_fcnt + 32'(fl);
    end
  endtask

  // Monitor: checks the queued expectation against the DUT at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        logic bad;
        mon_e = sb_q.pop_front();
        vectors++;
        bad = (bus.fetch_en !== mon_e.fe) || (bus.stall_fd !== mon_e.st) ||
              (bus.flush_fd !== mon_e.fl) || (bus.bubble_de !== mon_e.bu) ||
              (bus.fwd_rs1_sel !== mon_e.s1) || (bus.fwd_rs2_sel !== mon_e.s2) ||
              (bus.ohalt !== mon_e.oh);
`ifdef PERF_CNT_EN
        bad = bad || (stall_cnt !== mon_e.scnt) || (flush_cnt !== mon_e.fcnt);
        if (bad)
          $display("FAIL %s: got scnt=%0d fcnt=%0d want scnt=%0d fcnt=%0d",
                   mon_e.nm, stall_cnt, flush_cnt, mon_e.scnt, mon_e.fcnt);
`endif
        if (bad) begin
          miscompares++;
          $display("FAIL %s: got fe=%b st=%b fl=%b bu=%b s1=%0d s2=%0d oh=%b want fe=%b st=%b fl=%b bu=%b s1=%0d s2=%0d oh=%b",
                   mon_e.nm, bus.fetch_en, bus.stall_fd, bus.flush_fd, bus.bubble_de,
                   bus.fwd_rs1_sel, bus.fwd_rs2_sel, bus.ohalt,
                   mon_e.fe, mon_e.st, mon_e.fl, mon_e.bu, mon_e.s1, mon_e.s2, mon_e.oh);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.d_valid = 1'b0; bus.d_rs1 = '0; bus.d_use_rs1 = 1'b0; bus.d_rs2 = '0;
    bus.d_use_rs2 = 1'b0; bus.d_rd = '0; bus.d_wr_en = 1'b0; bus.d_is_load = 1'b0;
    bus.d_halt = 1'b0; bus.redirect = 1'b0;
    #1 rst = 1'b0;

    //   name                 r  v rs1 u1 rs2 u2 rd wr ld h rdr   fe st fl bu s1 s2 oh
    cyc("reset_a",            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("reset_b",            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    // ALU forwarding ages through stages 1..3
    cyc("alu_wr5",            1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("alu_fwd1",           1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0);
    cyc("alu_fwd2",           1, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2, 1, 0);
    cyc("alu_fwd3",           1, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 3, 2, 0);
    cyc("idle",               1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    // load-use: one stall, then forward from stage 2
    cyc("ld_wr7",             1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("ld_use_stall",       1, 1, 0, 0, 7, 1, 8, 1, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0);
    cyc("ld_use_fwd2",        1, 1, 0, 0, 7, 1, 8, 1, 0, 0, 0,   1, 0, 0, 0, 0, 2, 0);
    cyc("ld_fwd3",            1, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 3, 1, 0);
    // youngest writer priority and x0
    cyc("wr3_a",              1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("wr9",                1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("wr3_b",              1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("prio_youngest",      1, 1, 3, 1, 9, 1, 0, 1, 1, 0, 0,   1, 0, 0, 0, 1, 2, 0);
    cyc("x0_no_fwd",          1, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 0);
    // redirect overrides a pending load-use and kills the decode instruction
    cyc("ld_wr10",            1, 1, 0, 0, 0, 0,10, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("redirect_ld_use",    1, 1,10, 1, 0, 0,11, 1, 0, 0, 1,   1, 0, 1, 1, 0, 0, 0);
    cyc("after_redirect",     1, 1,10, 1,11, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2, 0, 0);
    // halt: fetch drops at acceptance, ohalt three cycles later and sticky
    cyc("halt_accept",        1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    cyc("drain_redirect_ign", 1, 1, 0, 0, 0, 0,12, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    cyc("drain",              1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    cyc("ohalt_t3",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    cyc("halted_sticky",      1, 1, 0, 0, 0, 0,13, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1);
    cyc("halted_ign_valid",   1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1);
    // reset from HALTED and from DRAIN
    cyc("reset_from_halted",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("halt_again",         1, 1, 0, 0, 0, 0,14, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    cyc("drain2",             1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    cyc("reset_in_drain",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("shadow_cleared",     1, 1,14, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("no_stale_halt",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("post_reset_wr4",     1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    cyc("post_reset_fwd",     1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0);

    @(posedge clk);
    #1;
    bus.d_valid = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
